cordic_iter_seq: RTL and testbench

//   Iteration sequencer for the CORDIC rotation/vectoring datapath of the SVD core.
//   On a start handshake it runs a programmable number of micro-rotations.
//   Per iteration it provides: shift amount, load/feedback mux select, datapath enable, and latched mode.

---
 rtl/cordic_iter_seq.sv | 102 ++++++++++
 tb/tb_cordic_iter_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_seq.sv
// Iteration sequencer for the CORDIC PEs: steps shift amount, operand select and
// register enable through a job of 1..MAX_IT micro-rotations, honouring datapath stalls.
module cordic_iter_seq #(
   parameter int unsigned SHIFT_W  = 4,
   parameter int unsigned DEF_ITER = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               mode_in_i,
   input  logic [SHIFT_W:0]   n_iter_i,
   input  logic               stall_i,
   output logic               ready_o,
   output logic               busy_o,
   output logic               sel_o,
   output logic [SHIFT_W-1:0] shift_bit_o,
   output logic [SHIFT_W-1:0] count_o,
   output logic               iter_en_o,
   output logic               mode_o,
   output logic               done_o
);

   localparam int unsigned    MaxIt    = 2 ** SHIFT_W;
   localparam logic [SHIFT_W:0] MaxItW   = (SHIFT_W + 1)'(MaxIt);
   localparam logic [SHIFT_W:0] DefIterW = (SHIFT_W + 1)'(DEF_ITER);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [SHIFT_W-1:0] count_q, count_d;
   logic               mode_q, mode_d;
   logic [SHIFT_W:0]   n_lat_q, n_lat_d;
   logic               last_iter;

   // n_lat is at least 1 whenever this is evaluated in StRun
   assign last_iter = ({1'b0, count_q} == (n_lat_q - 1'b1));

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mode_d    = mode_q;
      n_lat_d   = n_lat_q;
      ready_o   = 1'b0;
      busy_o    = 1'b0;
      sel_o     = 1'b0;
      iter_en_o = 1'b0;
      done_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready_o = 1'b1;
            if (start_i) begin
               mode_d  = mode_in_i;
               count_d = '0;
               state_d = StRun;
               if (n_iter_i == '0) begin
                  n_lat_d = DefIterW;
               end else if (n_iter_i > MaxItW) begin
                  n_lat_d = MaxItW;
               end else begin
                  n_lat_d = n_iter_i;
               end
            end
         end
         StRun: begin
            busy_o    = 1'b1;
            sel_o     = (count_q != '0);
            iter_en_o = !stall_i;
            if (!stall_i) begin
               if (last_iter) begin
                  state_d = StDone;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         mode_q  <= 1'b0;
         n_lat_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         n_lat_q <= n_lat_d;
      end
   end

   assign shift_bit_o = count_q;
   assign count_o     = count_q;
   assign mode_o      = mode_q;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Randomized self-checking bench for cordic_iter_seq; expectations come from a
// job-level model (iteration index, stall count, clamped iteration count).
module tb_cordic_iter_seq;

   localparam int unsigned SHIFT_W = 4;
   localparam int unsigned MAX_IT  = 16;
   localparam int unsigned DEF_IT  = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start_i;
   logic               mode_in_i;
   logic [SHIFT_W:0]   n_iter_i;
   logic               stall_i;
   logic               ready_o, busy_o, sel_o, iter_en_o, mode_o, done_o;
   logic [SHIFT_W-1:0] shift_bit_o, count_o;

   int n_checks = 0;
   int n_errors = 0;

   cordic_iter_seq #(
      .SHIFT_W  (SHIFT_W),
      .DEF_ITER (DEF_IT)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .mode_in_i   (mode_in_i),
      .n_iter_i    (n_iter_i),
      .stall_i     (stall_i),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .sel_o       (sel_o),
      .shift_bit_o (shift_bit_o),
      .count_o     (count_o),
      .iter_en_o   (iter_en_o),
      .mode_o      (mode_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // stall_mode: 0 none, 1 random, 2 three-cycle stalls on iterations 2 and 4
   task automatic run_job(input int n, input bit m, input int stall_mode, input bit hold);
      int exp_n, k, sc, guard;
      exp_n = (n == 0) ? DEF_IT : ((n > MAX_IT) ? MAX_IT : n);
      guard = 0;
      while (ready_o !== 1'b1 && guard < 40) begin
         @(posedge clk); #2;
         guard++;
      end
      check_eq("ready_before_accept", ready_o, 1);
      start_i   = 1'b1;
      mode_in_i = m;
      n_iter_i  = n[SHIFT_W:0];
      @(posedge clk); #1;
      start_i   = hold;
      mode_in_i = ~m;
      n_iter_i  = 5'($urandom_range(0, 31));
      k  = 0;
      sc = 0;
      while (k < exp_n) begin
         case (stall_mode)
            1:       stall_i = ($urandom_range(0, 3) == 0);
            2:       stall_i = ((k == 2 || k == 4) && sc < 3);
            default: stall_i = 1'b0;
         endcase
         #1;
         check_eq("run_busy", busy_o, 1);
         check_eq("run_ready", ready_o, 0);
         check_eq("run_done", done_o, 0);
         check_eq("run_iter_en", iter_en_o, !stall_i);
         check_eq("run_shift_bit", shift_bit_o, k);
         check_eq("run_count", count_o, k);
         check_eq("run_sel", sel_o, (k != 0));
         check_eq("run_mode", mode_o, m);
         if (stall_i) begin
            sc++;
         end else begin
            k++;
            sc = 0;
         end
         @(posedge clk); #1;
      end
      stall_i = 1'b0;
      #1;
      check_eq("done_pulse", done_o, 1);
      check_eq("done_busy", busy_o, 0);
      check_eq("done_ready", ready_o, 0);
      check_eq("done_iter_en", iter_en_o, 0);
      check_eq("done_sel", sel_o, 0);
      check_eq("done_count", count_o, exp_n - 1);
      @(posedge clk); #2;
      check_eq("idle_ready", ready_o, 1);
      check_eq("idle_done_low", done_o, 0);
      check_eq("idle_busy", busy_o, 0);
      check_eq("idle_mode_kept", mode_o, m);
      check_eq("idle_count_kept", count_o, exp_n - 1);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ready"}, ready_o, 1);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_count"}, count_o, 0);
      check_eq({tag, "_mode"}, mode_o, 0);
      check_eq({tag, "_done"}, done_o, 0);
      check_eq({tag, "_iter_en"}, iter_en_o, 0);
      check_eq({tag, "_sel"}, sel_o, 0);
   endtask

   task automatic reset_mid_job();
      int seen_done;
      start_i   = 1'b1;
      mode_in_i = 1'b1;
      n_iter_i  = 5'd16;
      @(posedge clk); #1;
      start_i = 1'b0;
      stall_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("pre_reset_shift", shift_bit_o, k);
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check_reset_state("mid_reset");
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done_o === 1'b1) seen_done++;
         @(posedge clk); #2;
      end
      check_eq("no_done_after_abort", seen_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      start_i   = 1'b0;
      mode_in_i = 1'b0;
      n_iter_i  = '0;
      stall_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check_reset_state("reset");

      run_job(4, 1'b1, 0, 1'b0);
      run_job(0, 1'b0, 0, 1'b0);
      run_job(20, 1'b1, 0, 1'b0);
      run_job(6, 1'b0, 2, 1'b0);
      // start held high across consecutive jobs
      run_job(3, 1'b1, 0, 1'b1);
      run_job(2, 1'b0, 0, 1'b1);
      run_job(5, 1'b1, 1, 1'b1);
      start_i = 1'b0;
      @(posedge clk); #2;
      check_eq("held_start_dropped_idle", ready_o, 1);
      run_job(1, 1'b0, 0, 1'b0);
      reset_mid_job();
      run_job(7, 1'b1, 1, 1'b0);

      for (int j = 0; j < 30; j++) begin
         run_job($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
      end
      start_i = 1'b0;
      @(posedge clk); #2;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
